pix_pack_tx: RTL and testbench

- Transmit-side pixel packer for the PixSend UART link.
- Accepts 12-bit pixels on a valid/ready interface into a small FIFO and splits each pixel into two UART bytes:
  - byte 0 = pix[11:4]
  - byte 1 = {pix[3:0], seq[3:0]}
- Drives a byte-level UART transmitter through a start/done handshake.
- Emits the 8-bit check code of each byte pair and a per-frame completion pulse, so link-side comparison against the receive path is possible.

---
 rtl/pix_pack_tx.sv | 191 +++++++++++++++++++
 tb/tb_pix_pack_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_pack_tx.sv
// Transmit-side pixel packer: buffers 12-bit pixels in a small FIFO and sends each
// as two UART bytes, reporting a per-pair check code and a per-frame completion pulse.
module pix_pack_tx #(
  parameter int unsigned FIFO_AW       = 2,
  parameter int unsigned PIX_PER_FRAME = 76800
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic [11:0] i_pix,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic [7:0]  o_check_code,
  output logic        o_check_valid,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SEQ_W  = 4;
  localparam int unsigned CNT_W  = 17;
  localparam int unsigned FILL_W = FIFO_AW + 1;
  localparam int unsigned DEPTH  = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  // ---------------------------------------------------------------- pixel FIFO
  logic [PIX_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FILL_W-1:0]  fill;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [PIX_W-1:0]   head;

  assign full  = (fill == FILL_W'(DEPTH));
  assign empty = (fill == '0);
  assign push  = i_pix_valid && !full;
  assign head  = mem[rd_ptr];

  // Gated with reset so the handshake reads 0 while held in reset.
  assign o_pix_ready = i_rst_n && !full;

  always_ff @(posedge i_clk_sys) begin
    if (push) begin
      mem[wr_ptr] <= i_pix;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // ---------------------------------------------------------------- byte FSM
  state_t             state_q;
  state_t             state_d;
  logic [PIX_W-1:0]   pix_q;
  logic [PIX_W-1:0]   pix_d;
  logic [SEQ_W-1:0]   seq_q;
  logic [SEQ_W-1:0]   seq_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [BYTE_W-1:0]  tx_data_q;
  logic [BYTE_W-1:0]  tx_data_d;
  logic               tx_start_q;
  logic               tx_start_d;
  logic [BYTE_W-1:0]  check_code_q;
  logic [BYTE_W-1:0]  check_code_d;
  logic               check_valid_q;
  logic               check_valid_d;
  logic               frame_done_q;
  logic               frame_done_d;
  logic [BYTE_W-1:0]  hi_byte;
  logic [BYTE_W-1:0]  lo_byte;

  assign hi_byte = pix_q[11:4];
  assign lo_byte = {pix_q[3:0], seq_q};

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      pix_q         <= '0;
      seq_q         <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      check_code_q  <= '0;
      check_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      seq_q         <= seq_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      check_code_q  <= check_code_d;
      check_valid_q <= check_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    seq_d         = seq_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    check_code_d  = check_code_q;
    check_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          pix_d      = head;
          tx_data_d  = head[11:4];
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (i_tx_done) begin
          tx_data_d     = lo_byte;
          tx_start_d    = 1'b1;
          check_code_d  = {hi_byte[7], hi_byte[4], hi_byte[3], hi_byte[0],
                           lo_byte[7], lo_byte[4], lo_byte[3], lo_byte[0]};
          check_valid_d = 1'b1;
          state_d       = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (i_tx_done) begin
          if (cnt_q == LAST_PIX) begin
            cnt_d        = '0;
            seq_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            seq_d = seq_q + SEQ_W'(1);
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_check_code  = check_code_q;
  assign o_check_valid = check_valid_q;
  assign o_frame_done  = frame_done_q;
  assign o_busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_pix_pack_tx.sv
// Bench for pix_pack_tx: three instances (large frame, 4-pixel frame, 1-pixel frame)
// share one stimulus stream and are scored against a per-pixel reference queue.
`timescale 1ns/1ps
module tb_pix_pack_tx;

  localparam int unsigned PPF0 = 76800;
  localparam int unsigned PPF1 = 4;
  localparam int unsigned PPF2 = 1;
  localparam int unsigned BIG  = 32'h7fff_ffff;

  typedef struct packed {
    logic [11:0]      pix;
    logic [2:0][3:0]  seq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pix = '0;
  logic        pix_valid = 1'b0;
  logic        tx_done = 1'b0;

  logic [2:0]  pix_ready;
  logic [7:0]  tx_data [3];
  logic [2:0]  tx_start;
  logic [7:0]  check_code [3];
  logic [2:0]  check_valid;
  logic [2:0]  frame_done;
  logic [2:0]  busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  exp_t        exp_q [$];
  int unsigned acc_cnt = 0;
  logic        byte_lo = 1'b0;
  int unsigned real_dones = 0;
  int unsigned done_limit = BIG;
  int unsigned frame_cnt [3];
  int unsigned start_cyc [$];
  int unsigned done_cyc [$];
  int unsigned push_cyc = 0;
  logic [7:0]  held [3];
  int unsigned max_dly = 3;
  logic        spur_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? PPF0 : ((g == 1) ? PPF1 : PPF2);
    pix_pack_tx #(.FIFO_AW(2), .PIX_PER_FRAME(P)) u_dut (
      .i_clk_sys    (clk),
      .i_rst_n      (rst_n),
      .i_pix        (pix),
      .i_pix_valid  (pix_valid),
      .o_pix_ready  (pix_ready[g]),
      .o_tx_data    (tx_data[g]),
      .o_tx_start   (tx_start[g]),
      .i_tx_done    (tx_done),
      .o_check_code (check_code[g]),
      .o_check_valid(check_valid[g]),
      .o_frame_done (frame_done[g]),
      .o_busy       (busy[g])
    );
  end

  function automatic int unsigned ppf_of(input int g);
    case (g)
      0:       return PPF0;
      1:       return PPF1;
      default: return PPF2;
    endcase
  endfunction

  function automatic logic [7:0] code_of(input logic [7:0] h, input logic [7:0] l);
    return {h[7], h[4], h[3], h[0], l[7], l[4], l[3], l[0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: pixel k since reset sits at frame position k mod PPF; seq is that mod 16.
  task automatic model_push(input logic [11:0] p);
    exp_t e;
    e.pix = p;
    for (int g = 0; g < 3; g++) begin
      e.seq[g] = 4'((acc_cnt % ppf_of(g)) % 16);
    end
    exp_q.push_back(e);
    acc_cnt++;
  endtask

  // Output scoreboard.
  exp_t       cur;
  logic [7:0] hi_b;
  logic [7:0] lo_b;
  logic [7:0] eb;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((|tx_start) || (|check_valid)) begin
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start", 32'(tx_start), 32'(0));
        end else begin
          cur = exp_q[0];
          for (int g = 0; g < 3; g++) begin
            hi_b = cur.pix[11:4];
            lo_b = {cur.pix[3:0], cur.seq[g]};
            eb   = byte_lo ? lo_b : hi_b;
            check_eq("tx_start", 32'(tx_start[g]), 32'(1));
            check_eq("tx_data", 32'(tx_data[g]), 32'(eb));
            check_eq("check_valid", 32'(check_valid[g]), 32'(byte_lo));
            if (byte_lo) check_eq("check_code", 32'(check_code[g]), 32'(code_of(hi_b, lo_b)));
            held[g] = eb;
          end
          if (byte_lo) void'(exp_q.pop_front());
          byte_lo = !byte_lo;
        end
      end
      for (int g = 0; g < 3; g++) begin
        if (frame_done[g]) begin
          frame_cnt[g]++;
          check_eq("frame_align", 32'((real_dones / 2) % ppf_of(g)), 32'(0));
        end
      end
    end
  end

  // UART transmitter model: answers each start with one done after a random delay.
  int unsigned dly = 0;
  logic        pend = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (tx_start[0]) begin
        pend = 1'b1;
        dly  = (max_dly == 0) ? 0 : $urandom_range(0, max_dly);
      end else if (pend) begin
        if (real_dones < done_limit) begin
          if (dly == 0) begin
            for (int g = 0; g < 3; g++) check_eq("tx_data_hold", 32'(tx_data[g]), 32'(held[g]));
            tx_done = 1'b1;
            pend    = 1'b0;
            real_dones++;
            done_cyc.push_back(cyc);
          end else begin
            dly--;
          end
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        tx_done = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq("rst_ready", 32'(pix_ready[g]), 32'(0));
      check_eq("rst_start", 32'(tx_start[g]), 32'(0));
      check_eq("rst_data", 32'(tx_data[g]), 32'(0));
      check_eq("rst_code", 32'(check_code[g]), 32'(0));
      check_eq("rst_cvalid", 32'(check_valid[g]), 32'(0));
      check_eq("rst_fdone", 32'(frame_done[g]), 32'(0));
      check_eq("rst_busy", 32'(busy[g]), 32'(0));
    end
    exp_q.delete();
    start_cyc.delete();
    done_cyc.delete();
    acc_cnt    = 0;
    byte_lo    = 1'b0;
    real_dones = 0;
    done_limit = BIG;
    for (int g = 0; g < 3; g++) frame_cnt[g] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq("post_rst_ready", 32'(pix_ready[g]), 32'(1));
      check_eq("post_rst_busy", 32'(busy[g]), 32'(0));
    end
    @(negedge clk);
  endtask

  task automatic push_pix(input logic [11:0] p);
    int n = 0;
    pix = p;
    pix_valid = 1'b1;
    while (pix_ready[0] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", 32'(pix_ready[0]), 32'(1));
    if (pix_ready[0] === 1'b1) model_push(p);
    push_cyc = cyc;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_dones(input int unsigned n_want);
    int n = 0;
    while (real_dones < n_want && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_wait", 32'(real_dones >= n_want), 32'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 3'b000) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("drain_queue", 32'(exp_q.size()), 32'(0));
    for (int g = 0; g < 3; g++) begin
      check_eq("drain_busy", 32'(busy[g]), 32'(0));
      check_eq("frame_count", 32'(frame_cnt[g]), 32'((real_dones / 2) / ppf_of(g)));
    end
  endtask

  task automatic check_gap(input string tag, input int si, input int di, input int unsigned want);
    if (si < start_cyc.size() && di < done_cyc.size())
      check_eq(tag, 32'(start_cyc[si] - done_cyc[di]), 32'(want));
    else
      check_eq(tag, 32'(start_cyc.size()), 32'(si + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single pixel: bytes A5, C0, code 98, start two edges after the write.
    max_dly = 3;
    push_pix(12'hA5C);
    for (int g = 0; g < 3; g++) check_eq("busy_after_push", 32'(busy[g]), 32'(1));
    wait_dones(2);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_eq("busy_drop", 32'(busy[g]), 32'(0));
    if (start_cyc.size() > 0) check_eq("first_latency", 32'(start_cyc[0] - push_cyc), 32'(2));
    else check_eq("first_latency", 32'(start_cyc.size()), 32'(1));
    check_gap("lo_after_hi_done", 1, 0, 1);
    wait_drain();

    // Two back-to-back pixels: exactly one idle cycle between pairs.
    start_cyc.delete();
    done_cyc.delete();
    max_dly = 0;
    push_pix(12'hA5C);
    push_pix(12'h123);
    wait_drain();
    check_gap("pair0_lo_gap", 1, 0, 1);
    check_gap("pair_idle_gap", 2, 1, 2);
    check_gap("pair1_lo_gap", 3, 2, 1);

    // Backpressure: transmitter stalled, 5 accepted, 6th refused.
    max_dly = 2;
    done_limit = real_dones;
    for (int i = 0; i < 5; i++) push_pix(12'($urandom));
    for (int g = 0; g < 3; g++) check_eq("full_ready", 32'(pix_ready[g]), 32'(0));
    pix = 12'($urandom);
    pix_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("still_full", 32'(pix_ready[0]), 32'(0));
    check_eq("accepted", 32'(exp_q.size()), 32'(5));
    pix_valid = 1'b0;
    done_limit = BIG;
    wait_drain();

    // Frame boundary: 5 pixels, PPF=4 instance must frame once.
    do_reset();
    max_dly = 3;
    for (int i = 0; i < 5; i++) push_pix(12'($urandom));
    wait_drain();
    check_eq("fd_ppf_big", 32'(frame_cnt[0]), 32'(0));
    check_eq("fd_ppf4", 32'(frame_cnt[1]), 32'(1));
    check_eq("fd_ppf1", 32'(frame_cnt[2]), 32'(5));

    // Reset while the low byte is in flight.
    done_limit = real_dones + 1;
    push_pix(12'hFFF);
    wait_dones(done_limit);
    repeat (3) @(negedge clk);
    check_eq("in_wait_lo_busy", 32'(busy[0]), 32'(1));
    do_reset();
    repeat (6) @(negedge clk);
    check_eq("no_start_after_rst", 32'(start_cyc.size()), 32'(0));
    push_pix(12'h5A7);
    wait_drain();

    // 20 consecutive pixels: seq wraps, spurious dones in IDLE ignored.
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 20; i++) push_pix(12'($urandom));
    wait_drain();
    check_eq("fd20_big", 32'(frame_cnt[0]), 32'(0));
    check_eq("fd20_ppf4", 32'(frame_cnt[1]), 32'(5));
    check_eq("fd20_ppf1", 32'(frame_cnt[2]), 32'(20));

    // Random traffic with gaps.
    for (int i = 0; i < 40; i++) begin
      push_pix(12'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
